// File: rtl/image_pad_loader_if.sv
// Bundles the loader's pixel stream input and its source-memory write port.
// master: the loader side. slave: the upstream source and the memory side.
interface image_pad_loader_if #(
  parameter int ADDR_W = 18
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_data;

  modport master (
    input  s_valid, s_data,
    output s_ready, m_we, m_addr, m_data
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, m_we, m_addr, m_data
  );
endinterface

// File: rtl/image_pad_loader.sv
// Writes a raster pixel stream into source frame memory with a one-pixel
// PAD_VALUE border, in strictly ascending address order.
//
// state  | meaning
// IDLE   | waiting for start after reset
// TOP    | writing the top border row (IMG_W+2 pads)
// LEFT   | writing column 0 of an image row
// PIX    | accepting IMG_W pixels of the current image row
// RIGHT  | writing column IMG_W+1 of an image row
// BOTTOM | writing the bottom border row (IMG_W+2 pads)
// DONE   | frame complete, done held until the next start
module image_pad_loader #(
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter int          ADDR_W    = 18,
  parameter logic [7:0]  PAD_VALUE = 8'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  image_pad_loader_if.master  bus,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 2);

  localparam logic [CW-1:0]     COL_PAD_LAST = CW'(IMG_W + 1);
  localparam logic [CW-1:0]     COL_PIX_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     ROW_LAST     = CW'(IMG_H - 1);
  localparam logic [CW-1:0]     CNT_ONE      = CW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TOP    = 3'd1,
    LEFT   = 3'd2,
    PIX    = 3'd3,
    RIGHT  = 3'd4,
    BOTTOM = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              pad_wr;

  // State, counters and the registered memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      m_we_q   <= 1'b0;
      m_addr_q <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
    end
  end

  // Next state and the write decided this cycle; pad writes share one path.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    col_d    = col_q;
    row_d    = row_q;
    busy_d   = busy_q;
    done_d   = done_q;
    m_we_d   = 1'b0;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    pad_wr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TOP;
          ptr_d   = '0;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      TOP: begin
        pad_wr = 1'b1;
        if (col_q == COL_PAD_LAST) begin
          col_d   = '0;
          state_d = LEFT;
        end else begin
          col_d = col_q + CNT_ONE;
        end
      end
      LEFT: begin
        pad_wr  = 1'b1;
        state_d = PIX;
      end
      PIX: begin
        if (bus.s_valid) begin
          m_we_d   = 1'b1;
          m_addr_d = ptr_q;
          m_data_d = bus.s_data;
          ptr_d    = ptr_q + ADDR_ONE;
          if (col_q == COL_PIX_LAST) begin
            col_d   = '0;
            state_d = RIGHT;
          end else begin
            col_d = col_q + CNT_ONE;
          end
        end
      end
      RIGHT: begin
        pad_wr = 1'b1;
        if (row_q == ROW_LAST) begin
          col_d   = '0;
          state_d = BOTTOM;
        end else begin
          row_d   = row_q + CNT_ONE;
          state_d = LEFT;
        end
      end
      BOTTOM: begin
        pad_wr = 1'b1;
        if (col_q == COL_PAD_LAST) begin
          col_d   = '0;
          state_d = DONE;
        end else begin
          col_d = col_q + CNT_ONE;
        end
      end
      DONE: begin
        // The last write is on the port this cycle, so done rises one cycle later.
        busy_d = 1'b0;
        done_d = 1'b1;
        if (start) begin
          state_d = TOP;
          ptr_d   = '0;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pad_wr) begin
      m_we_d   = 1'b1;
      m_addr_d = ptr_q;
      m_data_d = PAD_VALUE;
      ptr_d    = ptr_q + ADDR_ONE;
    end
  end

  assign bus.s_ready = (state_q == PIX);
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_data  = m_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_image_pad_loader.sv
// Bench for image_pad_loader on a 4x3 image with PAD_VALUE 8'hAA.
module tb_image_pad_loader;

  localparam int         W      = 4;
  localparam int         H      = 3;
  localparam int         AW     = 5;
  localparam logic [7:0] PAD    = 8'hAA;
  localparam int         TOT    = (W + 2) * (H + 2);
  localparam int         BUDGET = 2000;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;

  image_pad_loader_if #(.ADDR_W(AW)) bus ();

  image_pad_loader #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PAD_VALUE(PAD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [AW+7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      check("spurious_we", 32'(bus.m_we), 32'd0);
    end else if (bus.m_we === 1'b1) begin
      check("write_addr_data", 32'({bus.m_addr, bus.m_data}), 32'(exp_q.pop_front()));
    end
  end

  // One frame: optional inverted pixels, stall percentage, a start pulse at
  // pixel index restart_at (-1 none), and a reset after abort_at writes (-1 none).
  task automatic run_frame(input bit inv, input int stall_pct, input int restart_at,
                           input int abort_at);
    logic [7:0] px [W*H];
    int  dec, idx, cyc, r, c;
    bit  pix_loc, v, restarted;
    logic [7:0] d;
    for (int i = 0; i < W*H; i++) px[i] = inv ? ~8'(i + 1) : 8'(i + 1);
    for (int a = 0; a < TOT; a++) begin
      r = a / (W + 2);
      c = a % (W + 2);
      d = (r >= 1 && r <= H && c >= 1 && c <= W) ? px[(r-1)*W + (c-1)] : PAD;
      exp_q.push_back({AW'(a), d});
    end
    dec = 0; idx = 0; cyc = 0; restarted = 0;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("start_done_low", 32'(done), 32'd0);
    check("start_busy_high", 32'(busy), 32'd1);

    while (dec < TOT && cyc < BUDGET) begin
      if (abort_at >= 0 && dec == abort_at) break;
      r = dec / (W + 2);
      c = dec % (W + 2);
      pix_loc = (r >= 1 && r <= H && c >= 1 && c <= W);
      check("s_ready", 32'(bus.s_ready), 32'(pix_loc));
      v = ($urandom_range(99) >= 32'(stall_pct));
      bus.s_valid = v;
      bus.s_data  = (pix_loc && v) ? px[idx] : 8'($urandom);
      if (pix_loc && idx == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      if (!pix_loc) dec++;
      else if (v) begin
        dec++;
        idx++;
      end
      @(negedge clk);
      start = 1'b0;
      if (restart_at >= 0 && restarted) check("busy_after_restart", 32'(busy), 32'd1);
      cyc++;
    end
    bus.s_valid = 1'b0;
    if (cyc >= BUDGET) check("frame_timeout", 32'(dec), 32'(TOT));

    if (abort_at >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_m_we", 32'(bus.m_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_s_ready", 32'(bus.s_ready), 32'd0);
      check("rst_m_addr", 32'(bus.m_addr), 32'd0);
      check("rst_pending", 32'(exp_q.size()), 32'(TOT - abort_at));
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      check("after_rst_m_we", 32'(bus.m_we), 32'd0);
      return;
    end

    check("last_write_done_low", 32'(done), 32'd0);
    check("last_write_busy_high", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_high", 32'(done), 32'd1);
    check("busy_low", 32'(busy), 32'd0);
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.s_valid = 1'b1;
      @(negedge clk);
      check("done_holds", 32'(done), 32'd1);
      check("done_s_ready", 32'(bus.s_ready), 32'd0);
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", 32'(bus.s_ready), 32'd0);
    check("reset_m_we", 32'(bus.m_we), 32'd0);
    check("reset_m_addr", 32'(bus.m_addr), 32'd0);
    check("reset_m_data", 32'(bus.m_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    bus.s_valid = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;

    run_frame(0, 0, -1, -1);
    run_frame(1, 40, -1, -1);
    run_frame(0, 0, 5, -1);
    run_frame(0, 0, -1, 10);
    run_frame(0, 40, -1, -1);
    run_frame(1, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
